// File: rtl/bit_row_packer.sv
// Packs a serial bit stream (first bit -> row bit 0) into ROW_WIDTH-bit rows for frame-RAM write-back.
// Two row buffers: the assembly buffer fills while the output buffer waits for the RAM to accept.
module bit_row_packer #(
  parameter int ROW_WIDTH = 1280,
  parameter int IDX_W     = 11,
  parameter int NUM_ROWS  = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  input  logic                 flush,
  output logic [IDX_W-1:0]     bit_index,
  output logic [ROW_WIDTH-1:0] row_data,
  output logic [IDX_W-1:0]     row_len,
  output logic [ADDR_W-1:0]    row_addr,
  output logic                 row_valid,
  input  logic                 row_ready
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [ROW_WIDTH-1:0] asm_q, asm_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [ROW_WIDTH-1:0] row_data_q, row_data_d;
  logic [IDX_W-1:0]     row_len_q, row_len_d;
  logic [ADDR_W-1:0]    row_addr_q, row_addr_d;
  logic                 row_valid_q, row_valid_d;

  logic                 accept;
  logic                 out_fire;
  logic                 out_free;
  logic                 emit;
  logic [IDX_W-1:0]     len_now;
  logic [ROW_WIDTH-1:0] asm_next;
  logic [ADDR_W-1:0]    addr_next;

  assign bit_ready = (state_q == FILL);
  assign bit_index = idx_q;
  assign row_data  = row_data_q;
  assign row_len   = row_len_q;
  assign row_addr  = row_addr_q;
  assign row_valid = row_valid_q;

  assign accept    = bit_valid & (state_q == FILL);
  assign out_fire  = row_valid_q & row_ready;
  assign out_free  = ~row_valid_q | out_fire;
  assign len_now   = idx_q + {{(IDX_W-1){1'b0}}, accept};
  // A row closes on its last bit, or on flush when it holds at least one bit (this cycle's included).
  assign emit      = (state_q == FILL) &&
                     ((accept && (idx_q == IDX_W'(ROW_WIDTH - 1))) ||
                      (flush && (len_now != {IDX_W{1'b0}})));
  assign addr_next = (row_addr_q == ADDR_W'(NUM_ROWS - 1)) ? {ADDR_W{1'b0}}
                                                            : row_addr_q + ADDR_W'(1);

  // Decoder-style bit insert keeps the index width independent of ROW_WIDTH.
  always_comb begin
    asm_next = asm_q;
    for (int k = 0; k < ROW_WIDTH; k++) begin
      if (accept && (idx_q == IDX_W'(k))) begin
        asm_next[k] = bit_in;
      end else begin
        asm_next[k] = asm_q[k];
      end
    end
  end

  // In HOLD, idx_q keeps the held row's length so it can be handed to row_len on release.
  always_comb begin
    state_d     = state_q;
    asm_d       = asm_next;
    idx_d       = len_now;
    row_data_d  = row_data_q;
    row_len_d   = row_len_q;
    row_valid_d = row_valid_q & ~out_fire;
    row_addr_d  = out_fire ? addr_next : row_addr_q;
    case (state_q)
      FILL: begin
        if (emit) begin
          if (out_free) begin
            row_data_d  = asm_next;
            row_len_d   = len_now;
            row_valid_d = 1'b1;
            asm_d       = {ROW_WIDTH{1'b0}};
            idx_d       = {IDX_W{1'b0}};
          end else begin
            state_d = HOLD;
          end
        end else begin
          state_d = FILL;
        end
      end
      HOLD: begin
        asm_d = asm_q;
        idx_d = idx_q;
        if (out_fire) begin
          row_data_d  = asm_q;
          row_len_d   = idx_q;
          row_valid_d = 1'b1;
          asm_d       = {ROW_WIDTH{1'b0}};
          idx_d       = {IDX_W{1'b0}};
          state_d     = FILL;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      asm_q       <= {ROW_WIDTH{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      row_data_q  <= {ROW_WIDTH{1'b0}};
      row_len_q   <= {IDX_W{1'b0}};
      row_addr_q  <= {ADDR_W{1'b0}};
      row_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      asm_q       <= asm_d;
      idx_q       <= idx_d;
      row_data_q  <= row_data_d;
      row_len_q   <= row_len_d;
      row_addr_q  <= row_addr_d;
      row_valid_q <= row_valid_d;
    end
  end

endmodule

// File: tb/tb_bit_row_packer.sv
// Bench for bit_row_packer: a row-FIFO model (depth 2) checked every cycle plus literal pins.
module tb_bit_row_packer;
  localparam int RW = 1280;
  localparam int IW = 11;
  localparam int NR = 1024;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, bit_in = 1'b0, bit_valid = 1'b0, flush = 1'b0, row_ready = 1'b0;
  logic          bit_ready, row_valid;
  logic [IW-1:0] bit_index, row_len;
  logic [RW-1:0] row_data;
  logic [AW-1:0] row_addr;

  bit_row_packer #(.ROW_WIDTH(RW), .IDX_W(IW), .NUM_ROWS(NR), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .flush(flush), .bit_index(bit_index), .row_data(row_data), .row_len(row_len),
    .row_addr(row_addr), .row_valid(row_valid), .row_ready(row_ready));

  // Small instance: 8-bit rows, 4-row frame, for the address wrap.
  logic       s_bit_in = 1'b0, s_bit_valid = 1'b0, s_flush = 1'b0, s_row_ready = 1'b1;
  logic       s_bit_ready, s_row_valid;
  logic [3:0] s_bit_index, s_row_len;
  logic [7:0] s_row_data;
  logic [1:0] s_row_addr;

  bit_row_packer #(.ROW_WIDTH(8), .IDX_W(4), .NUM_ROWS(4), .ADDR_W(2)) dut_s (
    .clk(clk), .reset(reset), .bit_in(s_bit_in), .bit_valid(s_bit_valid), .bit_ready(s_bit_ready),
    .flush(s_flush), .bit_index(s_bit_index), .row_data(s_row_data), .row_len(s_row_len),
    .row_addr(s_row_addr), .row_valid(s_row_valid), .row_ready(s_row_ready));

  int n_checks = 0;
  int n_errors = 0;

  // Model: completed rows sit in a queue of at most two (output + held); front is on the port.
  typedef struct {
    logic [RW-1:0] d;
    int            len;
  } row_t;
  row_t          mq[$];
  logic [RW-1:0] m_cur = '0;
  int            m_len = 0;
  int            m_addr = 0;
  bit            m_acc = 1'b0;
  bit            chk_en = 1'b0;

  always @(posedge clk) begin : model
    int   qs0;
    bit   fire, emit;
    row_t r;
    if (reset) begin
      mq.delete();
      m_cur  = '0;
      m_len  = 0;
      m_addr = 0;
      m_acc  = 1'b0;
    end else begin
      qs0   = mq.size();
      fire  = (qs0 > 0) && row_ready;
      m_acc = bit_valid && (qs0 < 2);
      if (m_acc) begin
        m_cur[m_len] = bit_in;
        m_len++;
      end
      emit = (qs0 < 2) && ((m_len == RW) || (flush && m_len > 0));
      if (fire) begin
        void'(mq.pop_front());
        m_addr = (m_addr + 1) % NR;
      end
      if (emit) begin
        r.d   = m_cur;
        r.len = m_len;
        mq.push_back(r);
        m_cur = '0;
        m_len = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    int   exp_idx;
    bit   exp_rdy, exp_rv;
    row_t h;
    if (chk_en) begin
      exp_rdy = (mq.size() < 2);
      exp_rv  = (mq.size() > 0);
      exp_idx = m_len;
      if (mq.size() == 2) begin
        h       = mq[1];
        exp_idx = h.len;
      end
      n_checks++;
      if (bit_ready !== exp_rdy || row_valid !== exp_rv ||
          bit_index !== IW'(exp_idx) || row_addr !== AW'(m_addr)) begin
        n_errors++;
        $display("FAIL ctrl t=%0t: got rdy=%b vld=%b idx=%0d addr=%0d, want rdy=%b vld=%b idx=%0d addr=%0d",
                 $time, bit_ready, row_valid, bit_index, row_addr, exp_rdy, exp_rv, exp_idx, m_addr);
      end
      if (exp_rv) begin
        h = mq[0];
        n_checks++;
        if (row_data !== h.d || row_len !== IW'(h.len)) begin
          n_errors++;
          $display("FAIL row t=%0t: got len=%0d low64=%h, want len=%0d low64=%h",
                   $time, row_len, row_data[63:0], h.len, h.d[63:0]);
        end
      end
    end
  end

  logic [1:0] s_addr_q[$];
  logic [7:0] s_data_q[$];
  logic [3:0] s_len_q[$];
  always @(negedge clk) begin : small_mon
    if (s_row_valid && s_row_ready) begin
      s_addr_q.push_back(s_row_addr);
      s_data_q.push_back(s_row_data);
      s_len_q.push_back(s_row_len);
    end
  end

  task automatic pin(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    end
  endtask

  task automatic pin_row(input string nm, input logic [RW-1:0] exp);
    n_checks++;
    if (row_data !== exp) begin
      n_errors++;
      $display("FAIL %s: got low64=%h, want low64=%h", nm, row_data[63:0], exp[63:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bit until the packer takes it; rnd adds valid gaps, ready jitter and rare flushes.
  task automatic send(input logic b, input bit rnd);
    int g;
    bit done;
    g    = 0;
    done = 1'b0;
    bit_in = b;
    while (!done) begin
      bit_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
      if (rnd) begin
        row_ready = ($urandom_range(1) == 1);
        flush     = ($urandom_range(399) == 0);
      end
      tick();
      if (m_acc) done = 1'b1;
      g++;
      if (!done && g > 1000) begin
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout: got no accept in %0d cycles, want accept", g);
        done = 1'b1;
      end
    end
    bit_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [9:0] v10;
    logic [7:0] sv;
    int         exp_a[5];
    int         g;
    exp_a = '{0, 1, 2, 3, 0};

    reset = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
    chk_en = 1'b1;
    pin("rst_valid", 64'(row_valid), 64'd0);
    pin("rst_ready", 64'(bit_ready), 64'd1);
    pin("rst_index", 64'(bit_index), 64'd0);
    pin("rst_addr", 64'(row_addr), 64'd0);

    // Address wrap on the 8-bit / 4-row instance.
    for (int r = 0; r < 5; r++) begin
      sv = 8'hA0 + 8'(r);
      for (int k = 0; k < 8; k++) begin
        s_bit_valid = 1'b1;
        s_bit_in    = sv[k];
        tick();
      end
    end
    s_bit_valid = 1'b0;
    tick();
    tick();
    pin("t4_rows", 64'(s_addr_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < s_addr_q.size()) begin
        pin("t4_addr", 64'(s_addr_q[i]), 64'(exp_a[i]));
        pin("t4_data", 64'(s_data_q[i]), 64'(8'hA0 + 8'(i)));
        pin("t4_len", 64'(s_len_q[i]), 64'd8);
      end
    end
    pin("t4_idle", 64'({s_bit_ready, s_bit_index}), 64'h10);

    // Full row with alternating bits, RAM always ready.
    row_ready = 1'b1;
    for (int k = 0; k < RW; k++) send(k[0], 1'b0);
    pin("t1_valid", 64'(row_valid), 64'd1);
    pin_row("t1_data", {640{2'b10}});
    pin("t1_len", 64'(row_len), 64'd1280);
    pin("t1_addr", 64'(row_addr), 64'd0);
    tick();
    pin("t1_valid_gone", 64'(row_valid), 64'd0);

    // Two rows against a stalled RAM: row A held, row B parked in the assembly buffer.
    row_ready = 1'b0;
    for (int k = 0; k < RW; k++) send(1'b1, 1'b0);
    for (int k = 0; k < RW; k++) send(1'b0, 1'b0);
    pin("t2_ready_low", 64'(bit_ready), 64'd0);
    tick();
    tick();
    pin_row("t2_a_stable", {RW{1'b1}});
    pin("t2_a_addr", 64'(row_addr), 64'd1);
    row_ready = 1'b1;
    tick();
    pin("t2_b_valid", 64'(row_valid), 64'd1);
    pin_row("t2_b_data", {RW{1'b0}});
    pin("t2_b_addr", 64'(row_addr), 64'd2);
    pin("t2_ready_back", 64'(bit_ready), 64'd1);
    tick();
    pin("t2_drained", 64'(row_valid), 64'd0);

    // Partial row flush, then a flush with nothing assembled.
    v10 = 10'h373;
    for (int k = 0; k < 10; k++) send(v10[k], 1'b0);
    pin("t3_index", 64'(bit_index), 64'd10);
    flush_pulse();
    pin("t3_valid", 64'(row_valid), 64'd1);
    pin_row("t3_data", {{(RW-10){1'b0}}, 10'h373});
    pin("t3_len", 64'(row_len), 64'd10);
    pin("t3_addr", 64'(row_addr), 64'd3);
    tick();
    flush_pulse();
    pin("t3_empty_flush", 64'(row_valid), 64'd0);
    tick();
    pin("t3_addr_after", 64'(row_addr), 64'd4);

    // Flush arriving with the completing bit is an ordinary full row.
    for (int k = 0; k < RW - 1; k++) send(1'b1, 1'b0);
    flush = 1'b1;
    send(1'b1, 1'b0);
    pin("t3_full_flush_len", 64'(row_len), 64'd1280);
    tick();

    // Reset with a row on the port and 600 bits half-assembled.
    row_ready = 1'b0;
    for (int k = 0; k < RW; k++) send(1'b1, 1'b0);
    for (int k = 0; k < 600; k++) send(1'b1, 1'b0);
    pin("t5_pre_valid", 64'(row_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pin("t5_valid", 64'(row_valid), 64'd0);
    pin("t5_index", 64'(bit_index), 64'd0);
    pin("t5_addr", 64'(row_addr), 64'd0);
    row_ready = 1'b1;
    for (int k = 0; k < RW; k++) send(1'b0, 1'b0);
    pin_row("t5_fresh", {RW{1'b0}});
    pin("t5_fresh_addr", 64'(row_addr), 64'd0);
    tick();

    // Random valid gaps, RAM stalls and flushes over 20 rows of bits.
    for (int k = 0; k < 20 * RW; k++) send(1'($urandom_range(1)), 1'b1);
    row_ready = 1'b1;
    tick();
    tick();
    tick();
    flush_pulse();
    g = 0;
    while (row_valid && g < 20) begin
      tick();
      g++;
    end
    pin("t6_drained", 64'(row_valid), 64'd0);
    pin("t6_index", 64'(bit_index), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
